// File: rtl/bcd_converter_seq.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_converter_seq
//  Purpose  : Sequential double-dabble binary-to-BCD converter, one add-3/shift
//             step per clock, valid/ready handshakes, optional sign-magnitude
//             input and registered leading-zero mask for display blanking.
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_converter_seq #(
    parameter int BIN_W     = 16,
    parameter int DIGITS    = 5,
    parameter int SIGNED_EN = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin_in,
    input  logic                  sign_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  sign_out,
    output logic [DIGITS-1:0]     lz_mask,
    output logic                  busy
);

    localparam int c_BCD_W = 4 * DIGITS;
    localparam int c_SR_W  = c_BCD_W + BIN_W;
    localparam int c_CNT_W = $clog2(BIN_W + 1);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_SHIFT = 2'd1;
    localparam logic [1:0] c_S_DONE  = 2'd2;

    function automatic bit digits_sufficient();
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < DIGITS; i++) p = p * 64'd10;
        return p > ((64'd1 << BIN_W) - 64'd1);
    endfunction

    generate
        if (BIN_W < 2 || BIN_W > 32 || DIGITS < 1 || !digits_sufficient()) begin : g_param_check
            $error("bcd_converter_seq: DIGITS too small for BIN_W, or BIN_W out of range");
        end
    endgenerate

    logic [1:0]          r_state;
    logic [c_SR_W-1:0]   r_sr;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_sign;
    logic                r_in_ready;
    logic                r_out_valid;
    logic                r_busy;
    logic [c_BCD_W-1:0]  r_bcd;
    logic                r_sign_out;
    logic [DIGITS-1:0]   r_lz;

    logic                w_neg;
    logic [BIN_W-1:0]    w_mag;
    logic [c_SR_W-1:0]   w_sr_adj;
    logic [c_SR_W-1:0]   w_sr_next;
    logic [c_BCD_W-1:0]  w_bcd_next;
    logic [DIGITS-1:0]   w_lz_next;
    logic                w_upper_zero;

    // Only a set MSB counts as negative, so a zero magnitude never carries a sign.
    assign w_neg = (SIGNED_EN != 0) && sign_in && bin_in[BIN_W-1];
    assign w_mag = w_neg ? (~bin_in + {{(BIN_W-1){1'b0}}, 1'b1}) : bin_in;

    always_comb begin
        w_sr_adj = r_sr;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_sr[BIN_W + 4*d +: 4] >= 4'd5) begin
                w_sr_adj[BIN_W + 4*d +: 4] = r_sr[BIN_W + 4*d +: 4] + 4'd3;
            end
        end
    end

    assign w_sr_next  = {w_sr_adj[c_SR_W-2:0], 1'b0};
    assign w_bcd_next = w_sr_next[c_SR_W-1 -: c_BCD_W];

    always_comb begin
        w_lz_next    = '0;
        w_upper_zero = 1'b1;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            w_upper_zero = w_upper_zero & (w_bcd_next[4*d +: 4] == 4'd0);
            w_lz_next[d] = w_upper_zero;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_S_IDLE;
            r_sr        <= '0;
            r_cnt       <= '0;
            r_sign      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_bcd       <= '0;
            r_sign_out  <= 1'b0;
            r_lz        <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (in_valid) begin
                        r_sr       <= {{c_BCD_W{1'b0}}, w_mag};
                        r_cnt      <= c_CNT_W'(BIN_W);
                        r_sign     <= w_neg;
                        r_state    <= c_S_SHIFT;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                c_S_SHIFT: begin
                    r_sr  <= w_sr_next;
                    r_cnt <= r_cnt - 1'b1;
                    // Final iteration: publish the result on the same edge that enters DONE.
                    if (r_cnt == c_CNT_W'(1)) begin
                        r_state     <= c_S_DONE;
                        r_out_valid <= 1'b1;
                        r_bcd       <= w_bcd_next;
                        r_sign_out  <= r_sign & (|w_bcd_next);
                        r_lz        <= w_lz_next;
                    end
                end
                c_S_DONE: begin
                    if (out_ready) begin
                        r_state     <= c_S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= c_S_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign bcd_out   = r_bcd;
    assign sign_out  = r_sign_out;
    assign lz_mask   = r_lz;

endmodule
`default_nettype wire

// File: tb/tb_bcd_converter_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_converter_seq
//  Purpose  : Self-checking bench for bcd_converter_seq (16-bit signed-enabled
//             and 8-bit unsigned instances) with a queue-based scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_converter_seq;

    typedef struct {
        logic [19:0] bcd;
        logic        sgn;
        logic [4:0]  lz;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;
    int b_popped = 0;

    exp_t qa[$];
    exp_t qb[$];

    // 16-bit, signed-enabled instance
    logic        a_in_valid = 1'b0, a_in_ready, a_sign_in = 1'b0;
    logic [15:0] a_bin = '0;
    logic        a_out_valid, a_out_ready = 1'b0, a_sign_out, a_busy;
    logic [19:0] a_bcd;
    logic [4:0]  a_lz;

    // 8-bit, unsigned-only instance
    logic        b_in_valid = 1'b0, b_in_ready, b_sign_in = 1'b0;
    logic [7:0]  b_bin = '0;
    logic        b_out_valid, b_out_ready = 1'b0, b_sign_out, b_busy;
    logic [11:0] b_bcd;
    logic [2:0]  b_lz;

    bcd_converter_seq #(.BIN_W(16), .DIGITS(5), .SIGNED_EN(1)) u_dut_a (
        .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .bin_in(a_bin), .sign_in(a_sign_in), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .bcd_out(a_bcd), .sign_out(a_sign_out),
        .lz_mask(a_lz), .busy(a_busy)
    );

    bcd_converter_seq #(.BIN_W(8), .DIGITS(3), .SIGNED_EN(0)) u_dut_b (
        .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .bin_in(b_bin), .sign_in(b_sign_in), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .bcd_out(b_bcd), .sign_out(b_sign_out),
        .lz_mask(b_lz), .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: decimal digits by repeated division, leading zeros by magnitude compare.
    function automatic exp_t model(input logic [31:0] v, input bit neg, input int digits);
        exp_t e;
        logic [31:0] t;
        logic [31:0] p;
        t = v;
        e.bcd = '0;
        e.lz  = '0;
        for (int d = 0; d < digits; d++) begin
            e.bcd[4*d +: 4] = 4'(t % 10);
            t = t / 10;
        end
        p = 32'd1;
        for (int d = 1; d < digits; d++) begin
            p = p * 10;
            e.lz[d] = (v < p);
        end
        e.sgn = neg && (v != 0);
        return e;
    endfunction

    task automatic a_convert(input logic [15:0] bin, input bit sgn, input bit pulse);
        exp_t e;
        bit neg;
        logic [31:0] mag;
        int lat;
        neg = sgn && bin[15];
        mag = neg ? (32'd65536 - 32'(bin)) : 32'(bin);
        e = model(mag, neg, 5);
        @(negedge clk);
        chk("a_in_ready_idle", 32'(a_in_ready), 32'd1);
        a_bin = bin; a_sign_in = sgn; a_in_valid = 1'b1;
        @(posedge clk);
        qa.push_back(e);
        @(negedge clk);
        a_in_valid = 1'b0;
        chk("a_busy_shift", 32'(a_busy), 32'd1);
        lat = 0;
        while (!a_out_valid && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (pulse && lat == 4) begin
                a_bin = 16'd777; a_sign_in = 1'b0; a_in_valid = 1'b1;
            end else begin
                a_in_valid = 1'b0;
            end
        end
        a_in_valid = 1'b0;
        chk("a_latency", 32'(lat), 32'd16);
    endtask

    task automatic a_pop_check(output exp_t e);
        n_assert++;
        assert (qa.size() != 0) else begin
            n_fail++;
            $error("FAIL a_queue: observed empty expected entry");
        end
        if (qa.size() != 0) e = qa.pop_front();
        else e = '{bcd: '0, sgn: 1'b0, lz: '0};
        chk("a_bcd", 32'(a_bcd), 32'(e.bcd));
        chk("a_sign", 32'(a_sign_out), 32'(e.sgn));
        chk("a_lz", 32'(a_lz), 32'(e.lz));
    endtask

    task automatic a_release();
        @(negedge clk);
        a_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_out_ready = 1'b0;
        chk("a_out_valid_after_hs", 32'(a_out_valid), 32'd0);
        chk("a_in_ready_after_hs", 32'(a_in_ready), 32'd1);
    endtask

    // Consumer-side scoreboard for the 8-bit instance.
    always @(negedge clk) begin
        if (b_out_valid && b_out_ready) begin
            exp_t e;
            n_assert++;
            assert (qb.size() != 0) else begin
                n_fail++;
                $error("FAIL b_queue: observed unexpected result 0x%0h", b_bcd);
            end
            if (qb.size() != 0) begin
                e = qb.pop_front();
                b_popped++;
                chk("b_bcd", 32'(b_bcd), 32'(e.bcd[11:0]));
                chk("b_lz", 32'(b_lz), 32'(e.lz[2:0]));
                chk("b_sign", 32'(b_sign_out), 32'd0);
            end
        end
    end

    initial begin : main
        exp_t e;
        logic [31:0] snap;
        int hits;
        int lat;
        int guard;
        int prev_acc;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(a_in_ready), 32'd1);
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_bcd", 32'(a_bcd), 32'd0);
        chk("rst_sign", 32'(a_sign_out), 32'd0);
        chk("rst_lz", 32'(a_lz), 32'd0);
        reset = 1'b0;

        a_convert(16'd12345, 1'b0, 1'b0); a_pop_check(e); a_release();
        a_convert(16'd0,     1'b0, 1'b0); a_pop_check(e); a_release();
        a_convert(16'd65535, 1'b0, 1'b0); a_pop_check(e); a_release();
        a_convert(16'd9,     1'b0, 1'b0); a_pop_check(e); a_release();
        a_convert(16'h8000,  1'b1, 1'b0); a_pop_check(e); a_release();
        a_convert(16'hFFFF,  1'b1, 1'b0); a_pop_check(e); a_release();
        a_convert(16'h0010,  1'b1, 1'b0); a_pop_check(e); a_release();

        // Backpressure with stray in_valid pulses in SHIFT and DONE
        a_convert(16'd1234, 1'b0, 1'b1);
        a_pop_check(e);
        snap = {6'd0, e.lz, e.sgn, e.bcd};
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            a_in_valid = (k == 3);
            a_bin = 16'd777;
            chk("bp_outputs", {6'd0, a_lz, a_sign_out, a_bcd}, snap);
            chk("bp_in_ready", 32'(a_in_ready), 32'd0);
            chk("bp_out_valid", 32'(a_out_valid), 32'd1);
        end
        a_in_valid = 1'b0;
        a_release();
        hits = 0;
        repeat (20) begin
            @(negedge clk);
            if (a_out_valid) hits++;
        end
        chk("bp_no_stray_result", 32'(hits), 32'd0);
        chk("bp_held_after_hs", {6'd0, a_lz, a_sign_out, a_bcd}, snap);

        // Reset sampled on the 7th SHIFT edge of operand 4321
        @(negedge clk);
        a_bin = 16'd4321; a_sign_in = 1'b0; a_in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_in_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_in_ready", 32'(a_in_ready), 32'd1);
        chk("mid_rst_outputs", {6'd0, a_lz, a_sign_out, a_bcd, a_out_valid, a_busy}, 32'd0);
        hits = 0;
        repeat (20) begin
            @(negedge clk);
            if (a_out_valid) hits++;
        end
        chk("mid_rst_aborted", 32'(hits), 32'd0);
        a_convert(16'd100, 1'b0, 1'b0); a_pop_check(e); a_release();

        // 8-bit instance: directed 255 (sign_in ignored), then random back-to-back
        b_out_ready = 1'b1;
        @(negedge clk);
        b_bin = 8'd255; b_sign_in = 1'b1; b_in_valid = 1'b1;
        @(posedge clk);
        qb.push_back(model(32'd255, 1'b0, 3));
        @(negedge clk);
        b_in_valid = 1'b0;
        lat = 0;
        while (!b_out_valid && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        chk("b_latency", 32'(lat), 32'd8);

        prev_acc = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            b_bin = 8'($urandom);
            b_sign_in = 1'($urandom);
            b_in_valid = 1'b1;
            guard = 0;
            while (!b_in_ready && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 100) chk("b_accept_timeout", 32'(guard), 32'd0);
            if (i > 0) chk("b_spacing", 32'(cyc - prev_acc), 32'd10);
            prev_acc = cyc;
            qb.push_back(model(32'(b_bin), 1'b0, 3));
            @(posedge clk);
        end
        @(negedge clk);
        b_in_valid = 1'b0;
        guard = 0;
        while (qb.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        repeat (2) @(negedge clk);
        chk("b_pending", 32'(qb.size()), 32'd0);
        chk("b_results", 32'(b_popped), 32'd1001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
